// File: rtl/iter_div32.sv
// iter_div32: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, followed by a sign
// fix-up cycle. Divide-by-zero and signed overflow skip the iteration.
module iter_div32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        op_sel,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // Two's-complement magnitude; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return -v;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  // dvd_q holds the shifting dividend and accumulates the quotient bits.
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;

  logic              op_valid;
  logic              signed_op;
  logic              s1, s2;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] sel;

  assign op_valid = (op_sel[4:2] == 3'b101);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    result_d  = result_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    signed_op = ~op_sel[0];
    s1        = signed_op & rs1[DATA_W-1];
    s2        = signed_op & rs2[DATA_W-1];
    trial     = {rem_q, dvd_q[DATA_W-1]};
    diff      = trial - {1'b0, dvs_q};
    sel       = is_rem_q ? rem_q : dvd_q;

    case (state_q)
      S_IDLE: begin
        if (start && op_valid) begin
          is_rem_d = op_sel[1];
          neg_d    = op_sel[1] ? s1 : (s1 ^ s2);
          dvd_d    = signed_op ? mag(rs1) : rs1;
          dvs_d    = signed_op ? mag(rs2) : rs2;
          rem_d    = '0;
          cnt_d    = CNT_LAST;
          state_d  = S_CALC;
          // Special results are staged directly and finished in FIX.
          if (rs2 == '0) begin
            dvd_d   = '1;
            rem_d   = rs1;
            neg_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_FIX;
          end else if (signed_op && rs1 == MIN_NEG && rs2 == '1) begin
            dvd_d   = MIN_NEG;
            rem_d   = '0;
            neg_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_FIX;
          end
        end
      end
      S_CALC: begin
        // Restoring step: keep the difference only when it is non-negative.
        if (!diff[DATA_W]) rem_d = diff[DATA_W-1:0];
        else               rem_d = trial[DATA_W-1:0];
        dvd_d = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        result_d = neg_q ? negate(sel) : sel;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and the visible result, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Working registers; always loaded on accept before being used.
  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

endmodule

// File: tb/tb_iter_div32.sv
// tb_iter_div32: directed vectors for iter_div32 with a reference model
// built from plain integer division and the command timing rules.
module tb_iter_div32;

  localparam logic [4:0] OP_DIV  = 5'b10100;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b10110;
  localparam logic [4:0] OP_REMU = 5'b10111;
  localparam int LAT_N = 34;
  localparam int LAT_S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op_sel = 5'b0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  iter_div32 #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ||
           ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  int          cyc = 0;
  int          done_edge = 0;
  bit          m_busy = 1'b0;
  bit          exp_done = 1'b0;
  logic [31:0] exp_result = 32'd0;
  logic [31:0] pend = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy     <= 1'b0;
      exp_done   <= 1'b0;
      exp_result <= 32'd0;
    end else begin
      cyc      <= cyc + 1;
      exp_done <= 1'b0;
      if (m_busy && cyc == done_edge) begin
        exp_done   <= 1'b1;
        exp_result <= pend;
        m_busy     <= 1'b0;
      end else if (!m_busy && start && (op_sel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})) begin
        m_busy    <= 1'b1;
        pend      <= ref_res(op_sel, rs1, rs2);
        done_edge <= cyc + (is_special(op_sel, rs1, rs2) ? LAT_S - 1 : LAT_N - 1);
      end
    end
  end

  // Outputs are compared against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("model busy", {31'd0, busy}, {31'd0, m_busy});
    chk("model done", {31'd0, done}, {31'd0, exp_done});
    chk("model result", result, exp_result);
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    int          lat;
    bit          mid;
  } vec_t;

  vec_t tbl[14];

  task automatic run(input vec_t v, input int idx);
    int  nb;
    bit  got;
    string nm;
    nb  = 0;
    got = 1'b0;
    nm  = $sformatf("vec%0d", idx);
    start = 1'b1; op_sel = v.op; rs1 = v.a; rs2 = v.b;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; op_sel = OP_REMU; rs1 = $urandom; rs2 = $urandom;
      end
      if (v.mid && n == 10) begin start = 1'b1; op_sel = OP_DIVU; end
      if (v.mid && n == 11) start = 1'b0;
      if (busy) nb++;
      if (done) begin
        got = 1'b1;
        chk({nm, " latency"}, n, v.lat);
        chk({nm, " busy cycles"}, nb, v.lat - 1);
        chk({nm, " result"}, result, v.q);
      end
    end
    if (!got) chk({nm, " done timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{OP_DIV,  32'd100,        32'd7,          32'h0000_000E, LAT_N, 1'b0};
    tbl[1]  = '{OP_REM,  32'd100,        32'd7,          32'h0000_0002, LAT_N, 1'b1};
    tbl[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, LAT_N, 1'b0};
    tbl[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, LAT_N, 1'b0};
    tbl[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, LAT_N, 1'b0};
    tbl[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'h0000_0001, LAT_N, 1'b0};
    tbl[6]  = '{OP_DIVU, 32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF, LAT_N, 1'b0};
    tbl[7]  = '{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F, LAT_N, 1'b0};
    tbl[8]  = '{OP_DIV,  32'hFFFF_FFFE,  32'd2,          32'hFFFF_FFFF, LAT_N, 1'b0};
    tbl[9]  = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, LAT_N, 1'b0};
    tbl[10] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, LAT_S, 1'b0};
    tbl[11] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, LAT_S, 1'b0};
    tbl[12] = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF, LAT_S, 1'b0};
    tbl[13] = '{OP_REMU, 32'd5,          32'd0,          32'h0000_0005, LAT_S, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Each command is issued in the done cycle of the previous one.
    for (int i = 0; i < 14; i++) run(tbl[i], i);

    // Invalid op_sel must not start anything.
    @(negedge clk);
    start = 1'b1; op_sel = 5'b10000; rs1 = 32'd9; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("invalid op busy", {31'd0, busy}, 32'd0);
      chk("invalid op done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // Reset in the middle of a DIV aborts it.
    start = 1'b1; op_sel = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    begin
      int ndone;
      ndone = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) ndone++;
      end
      chk("no done after abort", ndone, 0);
    end
    run('{OP_DIV, 32'd1000, 32'd3, 32'h0000_014D, LAT_N, 1'b0}, 99);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global timeout got %0d want 0", 1);
    $fatal(1, "timeout");
  end

endmodule
